// File: rtl/weight_act_mac.sv
// Multiply-accumulate stage: pops paired weight/activation words, sums KERN_SIZE products,
// then rescales and saturates the sum into one output word per kernel.
module weight_act_mac #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int KERN_SIZE  = 9,
  parameter int FRAC_SHIFT = 8
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [DATA_W-1:0] weight_V_dout,
  input  logic                     weight_V_empty_n,
  output logic                     weight_V_read,
  input  logic signed [DATA_W-1:0] act_V_dout,
  input  logic                     act_V_empty_n,
  output logic                     act_V_read,
  output logic signed [DATA_W-1:0] output_V_din,
  input  logic                     output_V_full_n,
  output logic                     output_V_write
);

  localparam int CNT_W = (KERN_SIZE > 1) ? $clog2(KERN_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERN_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_OUT} state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;

  logic                       fire;
  logic                       drain;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    acc_shr;
  logic signed [DATA_W-1:0]   sat_val;

  // Both FIFOs pop together or not at all; strobes stay low while reset is held.
  assign fire  = !ap_rst && (state_q == ST_ACC) && weight_V_empty_n && act_V_empty_n;
  assign drain = !ap_rst && (state_q == ST_OUT) && output_V_full_n;

  assign weight_V_read  = fire;
  assign act_V_read     = fire;
  assign output_V_write = drain;
  assign output_V_din   = dout_q;

  assign prod    = weight_V_dout * act_V_dout;
  assign acc_sum = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign acc_shr = acc_sum >>> FRAC_SHIFT;

  always_comb begin
    if (acc_shr > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (acc_shr < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = acc_shr[DATA_W-1:0];
  end

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    tap_cnt_d = tap_cnt_q;
    acc_d     = acc_q;
    dout_d    = dout_q;
    case (state_q)
      ST_ACC: begin
        if (fire) begin
          if (tap_cnt_q == LAST_TAP) begin
            dout_d    = sat_val;
            acc_d     = '0;
            tap_cnt_d = '0;
            state_d   = ST_OUT;
          end else begin
            acc_d     = acc_sum;
            tap_cnt_d = tap_cnt_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (drain) state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q   <= ST_ACC;
      tap_cnt_q <= '0;
      acc_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      tap_cnt_q <= tap_cnt_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
    end
  end

endmodule

// File: tb/tb_weight_act_mac.sv
// Scoreboard bench for weight_act_mac: FIFO models feed the inputs, a golden model
// queues expected outputs, and every output write is checked against the queue head.
module tb_weight_act_mac;

  localparam int DATA_W     = 16;
  localparam int ACC_W      = 40;
  localparam int KS         = 9;
  localparam int FRAC_SHIFT = 8;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst;
  logic signed [DATA_W-1:0] weight_V_dout;
  logic                     weight_V_empty_n;
  logic                     weight_V_read;
  logic signed [DATA_W-1:0] act_V_dout;
  logic                     act_V_empty_n;
  logic                     act_V_read;
  logic signed [DATA_W-1:0] output_V_din;
  logic                     output_V_full_n;
  logic                     output_V_write;

  weight_act_mac #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .KERN_SIZE(KS), .FRAC_SHIFT(FRAC_SHIFT)
  ) dut (
    .ap_clk          (ap_clk),
    .ap_rst          (ap_rst),
    .weight_V_dout   (weight_V_dout),
    .weight_V_empty_n(weight_V_empty_n),
    .weight_V_read   (weight_V_read),
    .act_V_dout      (act_V_dout),
    .act_V_empty_n   (act_V_empty_n),
    .act_V_read      (act_V_read),
    .output_V_din    (output_V_din),
    .output_V_full_n (output_V_full_n),
    .output_V_write  (output_V_write)
  );

  always #5 ap_clk = ~ap_clk;

  int wq[$];
  int aq[$];
  int exp_q[$];

  int  nvec = 0;
  int  nerr = 0;
  int  cycle = 0;
  int  last_pop_cyc = 0;
  int  last_wr_cyc = 0;
  int  npop_w = 0;
  int  npop_a = 0;
  int  nwr = 0;
  bit  act_blk = 0;
  bit  full_blk = 0;
  bit  lat_chk = 1;
  bit  stream_chk = 0;
  bit  first_wr = 1;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic int model(input int w[KS], input int a[KS]);
    longint s = 0;
    for (int i = 0; i < KS; i++) s += longint'(w[i]) * longint'(a[i]);
    s = s >>> FRAC_SHIFT;
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return int'(s);
  endfunction

  task automatic drive_fifos();
    weight_V_empty_n = (wq.size() != 0);
    act_V_empty_n    = (aq.size() != 0) && !act_blk;
    weight_V_dout    = (wq.size() != 0) ? DATA_W'(wq[0]) : '0;
    act_V_dout       = (aq.size() != 0) ? DATA_W'(aq[0]) : '0;
    output_V_full_n  = !full_blk;
  endtask

  task automatic push_kernel(input int w[KS], input int a[KS]);
    for (int i = 0; i < KS; i++) begin
      wq.push_back(w[i]);
      aq.push_back(a[i]);
    end
    exp_q.push_back(model(w, a));
    drive_fifos();
  endtask

  task automatic push_const(input int wv, input int av);
    int w[KS];
    int a[KS];
    for (int i = 0; i < KS; i++) begin
      w[i] = wv;
      a[i] = av;
    end
    push_kernel(w, a);
  endtask

  task automatic push_random();
    int w[KS];
    int a[KS];
    for (int i = 0; i < KS; i++) begin
      w[i] = int'($urandom_range(0, 65535)) - 32768;
      a[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    push_kernel(w, a);
  endtask

  // One clock: sample and score at the falling edge, update FIFO models just after the rising edge.
  task automatic step();
    bit rd_w;
    bit rd_a;
    @(negedge ap_clk);
    check("rd_pair", act_V_read, weight_V_read);
    check("rd_wr_excl", weight_V_read & output_V_write, 0);
    if (ap_rst) check("rst_strobes", {weight_V_read, act_V_read, output_V_write}, 0);
    rd_w = weight_V_read;
    rd_a = act_V_read;
    if (rd_w) begin
      npop_w++;
      last_pop_cyc = cycle;
    end
    if (rd_a) npop_a++;
    if (output_V_write) begin
      check("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("result", output_V_din, exp_q.pop_front());
      if (lat_chk) check("wr_latency", cycle - last_pop_cyc, 1);
      if (stream_chk) begin
        if (!first_wr) check("stream_period", cycle - last_wr_cyc, 10);
        first_wr = 0;
      end
      last_wr_cyc = cycle;
      nwr++;
    end
    @(posedge ap_clk);
    #1;
    if (rd_w && wq.size() != 0) void'(wq.pop_front());
    if (rd_a && aq.size() != 0) void'(aq.pop_front());
    cycle++;
    drive_fifos();
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || wq.size() != 0 || aq.size() != 0); i++)
      step();
    check("drain_timeout", exp_q.size() + wq.size() + aq.size(), 0);
    step();
    step();
  endtask

  initial begin
    int saved_w[KS];
    int saved_a[KS];
    int exp_a;

    ap_rst = 1'b1;
    drive_fifos();

    // Basic kernel, loaded while reset is held: no strobes may fire during reset.
    push_const(256, 256);
    repeat (3) step();
    check("rst_din", output_V_din, 0);
    check("rst_write", output_V_write, 0);
    ap_rst = 1'b0;
    npop_w = 0;
    npop_a = 0;
    nwr    = 0;
    drain(40);
    check("basic_wpops", npop_w, 9);
    check("basic_apops", npop_a, 9);
    check("basic_writes", nwr, 1);
    check("basic_value", output_V_din, 2304);

    // Signed products and saturation at both rails.
    push_const(32767, 32767);
    push_const(-32768, 32767);
    push_const(-1, 1);
    drain(60);
    check("neg_small_value", output_V_din, -1);

    // Unbalanced inputs: same kernel unstalled, then with the activation FIFO held empty.
    for (int i = 0; i < KS; i++) begin
      saved_w[i] = int'($urandom_range(0, 65535)) - 32768;
      saved_a[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    push_kernel(saved_w, saved_a);
    drain(40);
    act_blk = 1;
    push_kernel(saved_w, saved_a);
    for (int i = 0; i < 5; i++) begin
      step();
      check("unbal_no_wread", weight_V_read, 0);
    end
    act_blk = 0;
    drive_fifos();
    drain(40);
    check("unbal_value", output_V_din, model(saved_w, saved_a));

    // Back-pressure: hold the output FIFO full for 20 cycles in OUT.
    lat_chk  = 0;
    full_blk = 1;
    drive_fifos();
    for (int i = 0; i < KS; i++) begin
      saved_w[i] = int'($urandom_range(0, 65535)) - 32768;
      saved_a[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    exp_a = model(saved_w, saved_a);
    push_kernel(saved_w, saved_a);
    push_random();
    for (int i = 0; i < 30 && wq.size() > KS; i++) step();
    check("bp_reach_out", wq.size(), KS);
    nwr = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_din_hold", output_V_din, exp_a);
      check("bp_no_read", weight_V_read | act_V_read, 0);
      check("bp_no_write", output_V_write, 0);
    end
    full_blk = 0;
    drive_fifos();
    drain(40);
    check("bp_writes", nwr, 2);
    lat_chk = 1;

    // Reset mid-kernel: four taps are consumed and then discarded.
    for (int i = 0; i < 4; i++) begin
      wq.push_back(100);
      aq.push_back(100);
    end
    drive_fifos();
    drain(20);
    ap_rst = 1'b1;
    step();
    step();
    check("midrst_din", output_V_din, 0);
    ap_rst = 1'b0;
    push_const(2, 128);
    drain(40);
    check("midrst_value", output_V_din, 9);

    // Streaming: 100 back-to-back random kernels, one write every 10 cycles.
    for (int k = 0; k < 100; k++) push_random();
    nwr        = 0;
    stream_chk = 1;
    first_wr   = 1;
    drain(1100);
    stream_chk = 0;
    check("stream_writes", nwr, 100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded at cycle %0d, expected completion", cycle);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_act_mac.md
Name: weight_act_mac

Overview:
- Downstream consumer of the layer weight streamer: pops one signed weight per tap from the weight FIFO and one signed activation from the activation FIFO.
- Accumulates KERN_SIZE products, rescales and saturates the sum, and pushes one result word into the output FIFO.
- Sits between the weight/window producers and the layer's bias/activation stage.
- All three stream interfaces are HLS ap_fifo style.

Parameters:
- DATA_W, 16, width of weight, activation and output words (equals coeff_width).
- ACC_W, 40, accumulator width; must be at least 2*DATA_W + clog2(KERN_SIZE).
- KERN_SIZE, 9, products per output word (kern_s of the layer, e.g. 3x3).
- FRAC_SHIFT, 8, arithmetic right shift applied to the final sum before saturation.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous active-high reset.
- weight_V_dout  in  DATA_W  signed weight from the weight FIFO.
- weight_V_empty_n  in  1  weight FIFO has data.
- weight_V_read  out  1  pop the weight FIFO.
- act_V_dout  in  DATA_W  signed activation from the activation FIFO.
- act_V_empty_n  in  1  activation FIFO has data.
- act_V_read  out  1  pop the activation FIFO.
- output_V_din  out  DATA_W  saturated result.
- output_V_full_n  in  1  output FIFO can accept a word.
- output_V_write  out  1  push to the output FIFO.

Behaviour:
- Reset (ap_rst=1 at a clock edge, highest priority, also mid-kernel or mid-output):
  - state=ACC, tap_cnt=0, acc=0, output_V_din=0.
  - All read/write strobes 0. The partial sum is discarded.
- FSM states: ACC, OUT.
- ACC state:
  - fire = weight_V_empty_n & act_V_empty_n. weight_V_read = act_V_read = fire, combinational, same cycle.
  - The two FIFOs are never popped independently. If only one has data, neither read is asserted and nothing changes.
  - On fire: acc <= acc + sext(w*a), where w*a is a signed 2*DATA_W product. tap_cnt increments.
  - On the fire with tap_cnt==KERN_SIZE-1:
    - final = acc + product.
    - output_V_din <= sat(final >>> FRAC_SHIFT), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - acc <= 0, tap_cnt <= 0, state <= OUT.
- OUT state:
  - output_V_write = output_V_full_n, combinational. output_V_din is held stable.
  - While full_n=0: stay in OUT, write=0, no FIFO reads (back-pressure stalls both inputs).
  - On the cycle write=1: state <= ACC. The next kernel's first pop can occur on the following cycle.
- Latency and throughput: the result appears on output_V_din one cycle after the last tap pop. Best-case throughput is KERN_SIZE+1 cycles per output.
- Shift is arithmetic (toward -inf). No rounding.
- The accumulator never wraps when ACC_W meets its constraint. Saturation is applied only at output.
- read and write strobes are never asserted in the same cycle.
- output_V_din changes only on entry to OUT or on reset.

Test Plan:
- Basic kernel: KERN_SIZE=9, all weights=256, all activations=256, full_n=1 -> one write, output_V_din=2304 (9*65536>>8); exactly 9 pops per FIFO; write 1 cycle after last pop.
- Signed and saturation:
  - weights=32767, acts=32767 -> output 32767.
  - weights=-32768, acts=32767 -> output -32768.
  - weights=-1, acts=1 for all taps -> -9>>>8 = -1.
- Unbalanced inputs: act FIFO empty for 5 cycles while weight FIFO full -> no weight_V_read during those cycles; the result equals the unstalled run's.
- Back-pressure: hold output_V_full_n=0 for 20 cycles in OUT -> output_V_din constant, zero reads, single write when full_n returns; the next kernel's result is correct.
- Reset mid-kernel: assert ap_rst after 4 taps, then feed 9 taps of w=2, a=128 -> output 9 (2304>>8); no contribution from the aborted taps.
- Streaming: 100 back-to-back kernels with random data, FIFOs never empty -> outputs match the golden model; one write every 10 cycles.
